// File: rtl/hilo_muldiv.sv
// Iterative 32x32 multiply / restoring divide feeding the HI/LO register pair.
// One iteration per cycle; the result is presented with a single-cycle write enable.
module hilo_muldiv #(
   parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        hilo_we,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        div_q, div_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] ma_q, ma_d;
   logic [31:0] mb_q, mb_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        sgn_op;
   logic        sa;
   logic        sb;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   logic [32:0] div_r;
   logic        div_ge;
   logic [32:0] div_sub;
   logic [63:0] div_nxt;
   logic [63:0] step;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign sgn_op = ~op[0];
   assign sa     = sgn_op & a[31];
   assign sb     = sgn_op & b[31];
   // 0x8000_0000 negates to itself, which read unsigned is exactly 2^31
   assign a_mag  = sa ? (32'd0 - a) : a;
   assign b_mag  = sb ? (32'd0 - b) : b;

   assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, ma_q};
   assign mul_nxt = acc_q[0] ? {mul_sum, acc_q[31:1]}
                             : {1'b0, acc_q[63:1]};

   // acc holds {remainder, dividend/quotient}; quotient bits shift in at the bottom
   assign div_r   = acc_q[63:31];
   assign div_ge  = div_r >= {1'b0, mb_q};
   assign div_sub = div_r - {1'b0, mb_q};
   assign div_nxt = div_ge ? {div_sub[31:0], acc_q[30:0], 1'b1}
                           : {acc_q[62:0], 1'b0};

   assign step     = div_q ? div_nxt : mul_nxt;
   assign prod_fix = neg_q ? (64'd0 - step) : step;
   assign quo_fix  = neg_q ? (32'd0 - step[31:0]) : step[31:0];
   assign rem_fix  = rneg_q ? (32'd0 - step[63:32]) : step[63:32];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start && !cancel) begin
               div_d  = op[1];
               neg_d  = sa ^ sb;
               rneg_d = sa;
               ma_d   = a_mag;
               mb_d   = b_mag;
               cnt_d  = 5'd0;
               acc_d  = op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
               if (op[1] && (b == 32'd0)) begin
                  hi_d    = a;
                  lo_d    = DIV0_LO;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (cancel) begin
               state_d = IDLE;
            end else begin
               acc_d = step;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_d = DONE;
                  if (div_q) begin
                     hi_d = rem_fix;
                     lo_d = quo_fix;
                  end else begin
                     hi_d = prod_fix[63:32];
                     lo_d = prod_fix[31:0];
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         ma_q    <= 32'd0;
         mb_q    <= 32'd0;
         acc_q   <= 64'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign hilo_we = (state_q == DONE);
   assign hi_out  = hi_q;
   assign lo_out  = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected HI/LO and latency queued at issue,
// compared when the write pulse appears.
module tb_hilo_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        hilo_we;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   hilo_muldiv dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .cancel  (cancel),
      .busy    (busy),
      .hilo_we (hilo_we),
      .hi_out  (hi_out),
      .lo_out  (lo_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          c0;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_hi = 32'd0;
   logic [31:0] last_lo = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (hilo_we) begin
         if (sbq.size() == 0) begin
            chk("spurious_we", {63'd0, hilo_we}, 64'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("hi", {32'd0, hi_out}, {32'd0, e.hi});
            chk("lo", {32'd0, lo_out}, {32'd0, e.lo});
            chk("latency", 64'(cyc - e.c0), 64'(e.lat));
            last_hi = e.hi;
            last_lo = e.lo;
         end
      end
   end

   function automatic logic [63:0] model(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      longint sx, sy, p, q, r;
      logic [63:0] ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         2'b00: begin
            p = sx * sy;
            return 64'(p);
         end
         2'b01: return ux * uy;
         2'b10: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {32'(ux % uy), 32'(ux / uy)};
         end
      endcase
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi,
                        input logic [31:0] elo);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.hi  = ehi;
      e.lo  = elo;
      e.c0  = cyc;
      e.lat = (o[1] && y == 32'd0) ? 0 : 32;
      sbq.push_back(e);
      chk("busy_accept", {63'd0, busy}, 64'd1);
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
      @(posedge clk);
      #1;
      chk("busy_idle", {63'd0, busy}, 64'd0);
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] ehi,
                      input logic [31:0] elo);
      issue(o, x, y, ehi, elo);
      drain();
   endtask

   initial begin
      logic [63:0] m;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          n;
      rst    = 1'b1;
      start  = 1'b0;
      cancel = 1'b0;
      op     = 2'b00;
      a      = 32'd0;
      b      = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_we", {63'd0, hilo_we}, 64'd0);
      chk("rst_hi", {32'd0, hi_out}, 64'd0);
      chk("rst_lo", {32'd0, lo_out}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
      run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run(2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
      run(2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);

      // divide by zero: pulse right after the start edge, busy one cycle
      issue(2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      chk("div0_busy", {63'd0, busy}, 64'd0);
      chk("div0_left", 64'(sbq.size()), 64'd0);
      sbq.delete();
      run(2'b10, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF);

      // DIV overflow case, then a start held through DONE and the next IDLE
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!hilo_we && n < 40);
      chk("b2b_we_seen", {63'd0, hilo_we}, 64'd1);
      start = 1'b1;
      op    = 2'b01;
      a     = 32'd2;
      b     = 32'd3;
      @(posedge clk);
      #1;
      chk("b2b_ignored", {63'd0, busy}, 64'd0);
      begin
         exp_t e;
         @(posedge clk);
         #1;
         start = 1'b0;
         e.hi  = 32'd0;
         e.lo  = 32'd6;
         e.c0  = cyc;
         e.lat = 32;
         sbq.push_back(e);
         chk("b2b_accept", {63'd0, busy}, 64'd1);
      end
      drain();

      // random operands against the arithmetic model
      for (int i = 0; i < 10; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 7) ? 32'd0 : $urandom;
         if (i == 3) rb = 32'd1;
         if (i == 4) ra = 32'h8000_0000;
         m = model(ro, ra, rb);
         run(ro, ra, rb, m[63:32], m[31:0]);
      end

      // cancel and start together in IDLE: cancel wins
      @(negedge clk);
      start  = 1'b1;
      cancel = 1'b1;
      op     = 2'b01;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cancel = 1'b0;
      chk("cancel_idle", {63'd0, busy}, 64'd0);

      // cancel on the 10th CALC cycle
      issue(2'b01, 32'd5, 32'd6, 32'd0, 32'd30);
      repeat (9) @(posedge clk);
      @(negedge clk);
      cancel = 1'b1;
      sbq.delete();
      @(posedge clk);
      #1;
      cancel = 1'b0;
      chk("cancel_busy", {63'd0, busy}, 64'd0);
      chk("cancel_we", {63'd0, hilo_we}, 64'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("cancel_hold_hi", {32'd0, hi_out}, {32'd0, last_hi});
      chk("cancel_hold_lo", {32'd0, lo_out}, {32'd0, last_lo});

      // reset in the middle of a divide
      issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      sbq.delete();
      @(posedge clk);
      #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_we", {63'd0, hilo_we}, 64'd0);
      chk("midrst_hi", {32'd0, hi_out}, 64'd0);
      chk("midrst_lo", {32'd0, lo_out}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_busy", {63'd0, busy}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
